i2c_bit_ctrl: RTL and testbench

- Bit-level I2C master engine downstream of the axil_i2c byte/command layer. It executes one bus primitive per command (START, STOP, WRITE bit, READ bit) and drives the open-drain SCL/SDA pads.
- Supports clock stretching, arbitration-loss detection and bus-busy tracking.
- Sits between the byte controller and the top-level pad signals.

---
 rtl/i2c_pkg.sv | 53 +++++
 rtl/i2c_pad_sync.sv | 35 +++
 rtl/i2c_bit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_i2c_bit_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C bit engine: command and phase encodings plus the
// per-phase pad level table.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        PH_D = 3'd4
    } phase_e;

    typedef struct packed {
        logic sda_rel;
        logic scl_rel;
        logic scl_keep;
    } pad_lvl_t;

    // Released = 1. scl_keep means SCL stays at whatever level it already has.
    function automatic pad_lvl_t pad_levels(i2c_cmd_e cmd, phase_e ph, logic din);
        pad_lvl_t lvl;
        lvl = '{sda_rel: 1'b1, scl_rel: 1'b1, scl_keep: 1'b0};
        case (cmd)
            CMD_START: begin
                case (ph)
                    PH_A:    lvl = '{sda_rel: 1'b1, scl_rel: 1'b1, scl_keep: 1'b1};
                    PH_B:    lvl = '{sda_rel: 1'b1, scl_rel: 1'b1, scl_keep: 1'b0};
                    PH_C:    lvl = '{sda_rel: 1'b0, scl_rel: 1'b1, scl_keep: 1'b0};
                    default: lvl = '{sda_rel: 1'b0, scl_rel: 1'b0, scl_keep: 1'b0};
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    PH_A:    lvl = '{sda_rel: 1'b0, scl_rel: 1'b0, scl_keep: 1'b0};
                    PH_B,
                    PH_C:    lvl = '{sda_rel: 1'b0, scl_rel: 1'b1, scl_keep: 1'b0};
                    default: lvl = '{sda_rel: 1'b1, scl_rel: 1'b1, scl_keep: 1'b0};
                endcase
            end
            CMD_WRITE: lvl = '{sda_rel: din, scl_rel: (ph == PH_B) || (ph == PH_C), scl_keep: 1'b0};
            default:   lvl = '{sda_rel: 1'b1, scl_rel: (ph == PH_B) || (ph == PH_C), scl_keep: 1'b0};
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/i2c_pad_sync.sv
// Two-flop synchronizers for the SCL/SDA pad inputs plus SDA edge detection.
// Flops reset to 1 so an idle (pulled-up) bus produces no edge after reset.
module i2c_pad_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s_o,
    output logic sda_s_o,
    output logic sda_rise_o,
    output logic sda_fall_o
);

    logic [1:0] scl_ff_q;
    logic [1:0] sda_ff_q;
    logic       sda_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_ff_q   <= 2'b11;
            sda_ff_q   <= 2'b11;
            sda_prev_q <= 1'b1;
        end else begin
            scl_ff_q   <= {scl_ff_q[0], scl_i};
            sda_ff_q   <= {sda_ff_q[0], sda_i};
            sda_prev_q <= sda_ff_q[1];
        end
    end

    assign scl_s_o    = scl_ff_q[1];
    assign sda_s_o    = sda_ff_q[1];
    assign sda_rise_o = sda_ff_q[1] & ~sda_prev_q;
    assign sda_fall_o = ~sda_ff_q[1] & sda_prev_q;

endmodule

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master: runs one START/STOP/WRITE/READ primitive per command
// as four timed phases, with clock stretching, arbitration loss and bus-busy.
module i2c_bit_ctrl
    import i2c_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [1:0]                cmd_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      din_i,
    output logic                      dout_o,
    output logic                      done_o,
    output logic                      al_o,
    output logic                      bus_busy_o,
    input  logic                      scl_pad_i,
    output logic                      scl_pad_o,
    output logic                      scl_padoen_o,
    input  logic                      sda_pad_i,
    output logic                      sda_pad_o,
    output logic                      sda_padoen_o
);

    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    phase_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    i2c_cmd_e                  cmd_q, cmd_d;
    logic                      din_q, din_d;
    logic                      dout_q, dout_d;
    logic                      done_q, done_d;
    logic                      al_q, al_d;
    logic                      busy_q, busy_d;
    logic                      scl_oen_q, scl_oen_d;
    logic                      sda_oen_q, sda_oen_d;
    logic [1:0]                rel_age_q, rel_age_d;

    logic     scl_s, sda_s, sda_rise, sda_fall;
    logic     stretch_hold, arb_lost, bus_stop;
    pad_lvl_t lvl;

    i2c_pad_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_pad_i),
        .sda_i      (sda_pad_i),
        .scl_s_o    (scl_s),
        .sda_s_o    (sda_s),
        .sda_rise_o (sda_rise),
        .sda_fall_o (sda_fall)
    );

    // scl_s lags the pad by two cycles, so a freshly released SCL is only
    // trusted once rel_age_q saturates; earlier lows are our own echo.
    assign stretch_hold = (state_q != IDLE) && scl_oen_q && (rel_age_q == 2'd2) && !scl_s;
    assign arb_lost     = (cmd_q == CMD_WRITE) && din_q && ((state_q == PH_B) || (state_q == PH_C))
                          && !sda_s && scl_s;
    // In START phase A a rise may still be the delayed echo of our own STOP.
    assign bus_stop     = (state_q != IDLE) && (cmd_q != CMD_STOP) && sda_rise && scl_s
                          && !((cmd_q == CMD_START) && (state_q == PH_A));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        din_d     = din_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        al_d      = 1'b0;
        busy_d    = busy_q;
        sda_oen_d = sda_oen_q;
        scl_oen_d = scl_oen_q;
        rel_age_d = rel_age_q;
        lvl       = '0;

        if (state_q == IDLE) begin
            if (cmd_valid_i) begin
                state_d = PH_A;
                cnt_d   = '0;
                cmd_d   = i2c_cmd_e'(cmd_i);
                din_d   = din_i;
            end
        end else if (arb_lost || bus_stop) begin
            state_d = IDLE;
            al_d    = 1'b1;
        end else if (!stretch_hold) begin
            if (cnt_q == prescale_i) begin
                cnt_d = '0;
                case (state_q)
                    PH_A: state_d = PH_B;
                    PH_B: state_d = PH_C;
                    PH_C: begin
                        state_d = PH_D;
                        if (cmd_q == CMD_READ) dout_d = sda_s;
                    end
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (al_d) begin
            sda_oen_d = 1'b1;
            scl_oen_d = 1'b1;
        end else if (state_d != IDLE) begin
            lvl       = pad_levels(cmd_d, state_d, din_d);
            sda_oen_d = lvl.sda_rel;
            scl_oen_d = lvl.scl_keep ? scl_oen_q : lvl.scl_rel;
        end

        if (scl_s && sda_fall)      busy_d = 1'b1;
        else if (scl_s && sda_rise) busy_d = 1'b0;

        if (!scl_oen_q)               rel_age_d = 2'd0;
        else if (rel_age_q != 2'd2)   rel_age_d = rel_age_q + 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= CMD_START;
            din_q     <= 1'b0;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
            al_q      <= 1'b0;
            busy_q    <= 1'b0;
            scl_oen_q <= 1'b1;
            sda_oen_q <= 1'b1;
            rel_age_q <= 2'd2;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            al_q      <= al_d;
            busy_q    <= busy_d;
            scl_oen_q <= scl_oen_d;
            sda_oen_q <= sda_oen_d;
            rel_age_q <= rel_age_d;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign dout_o       = dout_q;
    assign done_o       = done_q;
    assign al_o         = al_q;
    assign bus_busy_o   = busy_q;
    assign scl_pad_o    = 1'b0;
    assign sda_pad_o    = 1'b0;
    assign scl_padoen_o = scl_oen_q;
    assign sda_padoen_o = sda_oen_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: directed bus scenarios plus random
// START/bits/STOP transactions scored against a timing/behaviour model.
module tb_i2c_bit_ctrl;
    import i2c_pkg::*;

    localparam int PW = 16;
    localparam int W  = 36;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [PW-1:0] prescale_i;
    logic [1:0]    cmd_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          din_i;
    logic          dout_o, done_o, al_o, bus_busy_o;
    logic          scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic          slave_scl_low, slave_sda_low, arb_sda_low;
    logic          scl_line, sda_line;

    // Open-drain bus with pull-ups: low if anyone drives low.
    assign scl_line = scl_padoen_o & ~slave_scl_low;
    assign sda_line = sda_padoen_o & ~slave_sda_low & ~arb_sda_low;

    i2c_bit_ctrl #(.PRESCALE_WIDTH(PW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .prescale_i   (prescale_i),
        .cmd_i        (cmd_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .din_i        (din_i),
        .dout_o       (dout_o),
        .done_o       (done_o),
        .al_o         (al_o),
        .bus_busy_o   (bus_busy_o),
        .scl_pad_i    (scl_line),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_e;
    logic          model_busy, model_dout;
    int unsigned   next_free, last_k;
    int unsigned   p_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_neg(input int unsigned target);
        while (cyc < target) @(negedge clk_i);
    endtask

    task automatic at_post(input int unsigned target);
        forever begin
            @(posedge clk_i);
            #1;
            if (cyc >= target) break;
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    // Expected completion: 4 phases of (P+1) cycles, done one cycle later,
    // plus any SCL stretch; arbitration loss reported 3 cycles into phase C.
    task automatic issue(input logic [1:0] cmd, input logic din, input logic rd_bit,
                         input int unsigned stretch, input bit expect_al, input bit chained);
        int n;
        int unsigned k, p, c;
        logic [W-1:0] e;
        cmd_i       = cmd;
        din_i       = din;
        cmd_valid_i = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) begin
            chk("accept_timeout", cmd_ready_o, 1);
            cmd_valid_i = 1'b0;
            return;
        end
        k = cyc;
        p = p_cur;
        last_k = k;
        if (chained) chk("b2b_accept_cycle", k, next_free);
        slave_sda_low = (cmd == CMD_READ) && !rd_bit;
        if (cmd == CMD_READ)  model_dout = rd_bit;
        if (cmd == CMD_START) model_busy = 1'b1;
        if (cmd == CMD_STOP)  model_busy = 1'b0;
        if (expect_al) begin
            c = k + 2 * p + 6;
            e = {2'd2, model_dout, model_busy, c};
        end else begin
            c = k + 4 * (p + 1) + 1 + stretch;
            e = {2'd1, model_dout, model_busy, c};
        end
        next_free = c;
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk_i);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (!rst_i && (done_o || al_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {al_o, done_o}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", {al_o, done_o}, mon_e[35:34]);
                chk("event_cycle", cyc, mon_e[31:0]);
                chk("dout", dout_o, mon_e[33]);
                chk("ready_at_event", cmd_ready_o, 1);
                if (mon_e[35:34] == 2'd1) begin
                    chk("bus_busy", bus_busy_o, mon_e[32]);
                end else begin
                    chk("al_scl_released", scl_padoen_o, 1);
                    chk("al_sda_released", sda_padoen_o, 1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int unsigned k, c0, d0, nhi, nb;
        rst_i = 1'b1;
        cmd_i = 2'd0;
        din_i = 1'b0;
        cmd_valid_i = 1'b0;
        slave_scl_low = 1'b0;
        slave_sda_low = 1'b0;
        arb_sda_low = 1'b0;
        model_busy = 1'b0;
        model_dout = 1'b0;
        next_free = 0;
        last_k = 0;
        p_cur = 4;
        prescale_i = PW'(p_cur);

        repeat (10) @(negedge clk_i);
        chk("rst_scl_padoen", scl_padoen_o, 1);
        chk("rst_sda_padoen", sda_padoen_o, 1);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_al", al_o, 0);
        chk("rst_dout", dout_o, 0);
        chk("rst_busy", bus_busy_o, 0);
        chk("scl_pad_o_const", scl_pad_o, 0);
        chk("sda_pad_o_const", sda_pad_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // START on idle bus: SDA falls at phase C with SCL high, SCL falls at D.
        issue(CMD_START, 1'b0, 1'b1, 0, 0, 0);
        cmd_valid_i = 1'b0;
        k  = last_k;
        c0 = k + 2 * p_cur + 3;
        d0 = k + 3 * p_cur + 4;
        wait_neg(c0 - 1);
        chk("start_sda_before_c", sda_padoen_o, 1);
        wait_neg(c0);
        chk("start_sda_at_c", sda_padoen_o, 0);
        chk("start_scl_at_c", scl_padoen_o, 1);
        wait_neg(c0 + 3);
        chk("start_busy_set", bus_busy_o, 1);
        wait_neg(d0 - 1);
        chk("start_scl_before_d", scl_padoen_o, 1);
        wait_neg(d0);
        chk("start_scl_at_d", scl_padoen_o, 0);
        drain();

        // WRITE 1 / READ with slave low, then WRITE 1 / READ released.
        issue(CMD_WRITE, 1'b1, 1'b1, 0, 0, 0);
        cmd_valid_i = 1'b0;
        drain();
        issue(CMD_READ, 1'b1, 1'b0, 0, 0, 0);
        cmd_valid_i = 1'b0;
        drain();
        issue(CMD_WRITE, 1'b1, 1'b1, 0, 0, 0);
        issue(CMD_READ, 1'b1, 1'b1, 0, 0, 1);
        cmd_valid_i = 1'b0;
        drain();

        // Clock stretching: slave holds SCL low 30 cycles from the start of phase B.
        issue(CMD_WRITE, 1'b1, 1'b1, 30, 0, 0);
        cmd_valid_i = 1'b0;
        k = last_k;
        at_post(k + p_cur + 1);
        slave_scl_low = 1'b1;
        at_post(k + p_cur + 2 + 30);
        slave_scl_low = 1'b0;
        nhi = 0;
        forever begin
            @(negedge clk_i);
            if (!scl_line || nhi >= 100) break;
            nhi++;
        end
        chk("stretch_scl_high_bc", nhi, 2 * (p_cur + 1));
        drain();

        // Arbitration: another master pulls SDA low during phase C of a WRITE 1.
        issue(CMD_WRITE, 1'b1, 1'b1, 0, 1, 0);
        cmd_valid_i = 1'b0;
        k  = last_k;
        c0 = k + 2 * p_cur + 3;
        at_post(c0);
        arb_sda_low = 1'b1;
        at_post(c0 + 4);
        arb_sda_low = 1'b0;
        model_busy = 1'b0;
        wait_neg(c0 + 8);
        chk("busy_after_foreign_stop", bus_busy_o, 0);
        drain();

        // STOP after START: SDA rises during phase D with SCL high.
        issue(CMD_START, 1'b0, 1'b1, 0, 0, 0);
        cmd_valid_i = 1'b0;
        drain();
        issue(CMD_STOP, 1'b0, 1'b1, 0, 0, 0);
        cmd_valid_i = 1'b0;
        k  = last_k;
        d0 = k + 3 * p_cur + 4;
        wait_neg(d0 - 1);
        chk("stop_sda_before_d", sda_padoen_o, 0);
        wait_neg(d0);
        chk("stop_sda_at_d", sda_padoen_o, 1);
        chk("stop_scl_at_d", scl_padoen_o, 1);
        drain();

        // Back-to-back with cmd_valid_i held high.
        issue(CMD_START, 1'b0, 1'b1, 0, 0, 0);
        issue(CMD_WRITE, 1'b0, 1'b1, 0, 0, 1);
        issue(CMD_STOP, 1'b0, 1'b1, 0, 0, 1);
        cmd_valid_i = 1'b0;
        drain();

        // Reset in the middle of a WRITE 0 releases both lines immediately.
        issue(CMD_START, 1'b0, 1'b1, 0, 0, 0);
        cmd_valid_i = 1'b0;
        drain();
        issue(CMD_WRITE, 1'b0, 1'b1, 0, 0, 0);
        cmd_valid_i = 1'b0;
        k = last_k;
        wait_neg(k + 2 * p_cur + 4);
        chk("pre_reset_sda_driven", sda_padoen_o, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_sda_rel", sda_padoen_o, 1);
        chk("async_rst_scl_rel", scl_padoen_o, 1);
        exp_q.delete();
        model_busy = 1'b0;
        model_dout = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("post_rst_ready", cmd_ready_o, 1);
        chk("post_rst_busy", bus_busy_o, 0);
        chk("post_rst_no_done", done_o, 0);

        // Random transactions: START, 1-4 random bits, STOP, all chained.
        for (int s = 0; s < 8; s++) begin
            p_cur = $urandom_range(2, 6);
            prescale_i = PW'(p_cur);
            nb = $urandom_range(1, 4);
            issue(CMD_START, 1'b0, 1'b1, 0, 0, 0);
            for (int b = 0; b < int'(nb); b++) begin
                if ($urandom_range(0, 1) == 1)
                    issue(CMD_READ, 1'b1, 1'($urandom_range(0, 1)), 0, 0, 1);
                else
                    issue(CMD_WRITE, 1'($urandom_range(0, 1)), 1'b1, 0, 0, 1);
            end
            issue(CMD_STOP, 1'b0, 1'b1, 0, 0, 1);
            cmd_valid_i = 1'b0;
            drain();
        end

        repeat (5) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
